// File: rtl/mp3_frame_header_writer.sv
// MPEG-1 Layer III frame header / CRC-16 / side-info byte serializer.
// Fields are captured on an accepted start; the header and side info are
// packed into one 288-bit shift register and streamed MSB first over a
// valid/ready handshake. For protected frames the CRC is computed serially
// from the packed register before the first byte is offered.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start_in
// S_CRC      | one CRC bit per cycle over header[15:0] + side info
// S_SEND_HDR | streaming the 4 header bytes
// S_SEND_CRC | streaming crc[15:8] then crc[7:0]
// S_SEND_SI  | streaming 17 (mono) or 32 (dual-channel) side-info bytes
// S_DONE     | one-cycle done pulse; a new start is accepted here too
module mp3_frame_header_writer (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             crc_en_in,
  input  logic [3:0]       bitrate_idx_in,
  input  logic [1:0]       samp_idx_in,
  input  logic             padding_in,
  input  logic             private_in,
  input  logic             copyright_in,
  input  logic             original_in,
  input  logic [1:0]       mode_in,
  input  logic [1:0]       mode_ext_in,
  input  logic [1:0]       emphasis_in,
  input  logic [8:0]       main_data_begin_in,
  input  logic [4:0]       private_bits_in,
  input  logic [7:0]       scfsi_in,
  input  logic [3:0][58:0] gc_info_in,
  output logic [7:0]       byte_out,
  output logic             byte_valid_out,
  input  logic             byte_ready_in,
  output logic             busy_out,
  output logic             done_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRC,
    S_SEND_HDR,
    S_SEND_CRC,
    S_SEND_SI,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [287:0]   sr_q;
  logic [15:0]    crc_q;
  logic [8:0]     bit_cnt_q;
  logic [4:0]     byte_cnt_q;
  logic           mono_q;
  logic           prot_q;

  logic           start_ok;
  logic           xfer;
  logic [31:0]    hdr_word;
  logic [255:0]   si_mono;
  logic [255:0]   si_stereo;
  logic [287:0]   sr_init;
  logic [8:0]     crc_idx;
  logic           crc_fb;
  logic [15:0]    crc_next;
  logic [8:0]     crc_last;
  logic [4:0]     si_last;

  // Pack the live input fields into the frame image loaded on start.
  always_comb begin
    hdr_word  = {12'hFFF, 1'b1, 2'b01, ~crc_en_in, bitrate_idx_in, samp_idx_in,
                 padding_in, private_in, mode_in, mode_ext_in,
                 copyright_in, original_in, emphasis_in};
    si_mono   = {main_data_begin_in, private_bits_in, scfsi_in[7:4],
                 gc_info_in[0], gc_info_in[2], 120'd0};
    si_stereo = {main_data_begin_in, private_bits_in[2:0], scfsi_in,
                 gc_info_in[0], gc_info_in[1], gc_info_in[2], gc_info_in[3]};
    sr_init   = {hdr_word, (mode_in == 2'b11) ? si_mono : si_stereo};
  end

  // Serial CRC step; the CRC covers sr_q[271:0] (header[15:0] onward), MSB first.
  always_comb begin
    crc_idx  = 9'd271 - bit_cnt_q;
    crc_fb   = crc_q[15] ^ sr_q[crc_idx];
    crc_next = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h8005 : 16'h0000);
    crc_last = mono_q ? 9'd151 : 9'd271;
    si_last  = mono_q ? 5'd16 : 5'd31;
  end

  // A byte moves whenever a send state meets a ready consumer.
  assign xfer = byte_ready_in &&
                ((state_q == S_SEND_HDR) || (state_q == S_SEND_CRC) || (state_q == S_SEND_SI));

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and output generation.
  always_comb begin
    state_d        = state_q;
    byte_out       = 8'h00;
    byte_valid_out = 1'b0;
    busy_out       = 1'b1;
    done_out       = 1'b0;
    start_ok       = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_out = 1'b0;
        if (start_in) begin
          start_ok = 1'b1;
          state_d  = crc_en_in ? S_CRC : S_SEND_HDR;
        end
      end
      S_CRC: begin
        if (bit_cnt_q == crc_last) state_d = S_SEND_HDR;
      end
      S_SEND_HDR: begin
        byte_valid_out = 1'b1;
        byte_out       = sr_q[287:280];
        if (xfer && byte_cnt_q == 5'd3) state_d = prot_q ? S_SEND_CRC : S_SEND_SI;
      end
      S_SEND_CRC: begin
        byte_valid_out = 1'b1;
        byte_out       = byte_cnt_q[0] ? crc_q[7:0] : crc_q[15:8];
        if (xfer && byte_cnt_q == 5'd1) state_d = S_SEND_SI;
      end
      S_SEND_SI: begin
        byte_valid_out = 1'b1;
        byte_out       = sr_q[287:280];
        if (xfer && byte_cnt_q == si_last) state_d = S_DONE;
      end
      S_DONE: begin
        busy_out = 1'b0;
        done_out = 1'b1;
        state_d  = S_IDLE;
        if (start_in) begin
          start_ok = 1'b1;
          state_d  = crc_en_in ? S_CRC : S_SEND_HDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame image, CRC accumulator and section counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sr_q       <= '0;
      crc_q      <= 16'hFFFF;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      mono_q     <= 1'b0;
      prot_q     <= 1'b0;
    end else if (start_ok) begin
      sr_q       <= sr_init;
      crc_q      <= 16'hFFFF;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      mono_q     <= (mode_in == 2'b11);
      prot_q     <= crc_en_in;
    end else begin
      if (state_q == S_CRC) begin
        crc_q     <= crc_next;
        bit_cnt_q <= bit_cnt_q + 9'd1;
      end
      // The CRC section reads crc_q, so the image only shifts in header/SI.
      if (xfer && (state_q != S_SEND_CRC)) sr_q <= {sr_q[279:0], 8'h00};
      if (state_d != state_q) byte_cnt_q <= '0;
      else if (xfer)          byte_cnt_q <= byte_cnt_q + 5'd1;
    end
  end

endmodule

// File: tb/tb_mp3_frame_header_writer.sv
module tb_mp3_frame_header_writer;

  logic             clk_in = 1'b0;
  logic             rst_in, start_in, crc_en_in;
  logic [3:0]       bitrate_idx_in;
  logic [1:0]       samp_idx_in;
  logic             padding_in, private_in, copyright_in, original_in;
  logic [1:0]       mode_in, mode_ext_in, emphasis_in;
  logic [8:0]       main_data_begin_in;
  logic [4:0]       private_bits_in;
  logic [7:0]       scfsi_in;
  logic [3:0][58:0] gc_info_in;
  logic [7:0]       byte_out;
  logic             byte_valid_out, byte_ready_in, busy_out, done_out;

  always #5 clk_in = ~clk_in;

  mp3_frame_header_writer dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .crc_en_in(crc_en_in),
    .bitrate_idx_in(bitrate_idx_in), .samp_idx_in(samp_idx_in),
    .padding_in(padding_in), .private_in(private_in),
    .copyright_in(copyright_in), .original_in(original_in),
    .mode_in(mode_in), .mode_ext_in(mode_ext_in), .emphasis_in(emphasis_in),
    .main_data_begin_in(main_data_begin_in), .private_bits_in(private_bits_in),
    .scfsi_in(scfsi_in), .gc_info_in(gc_info_in),
    .byte_out(byte_out), .byte_valid_out(byte_valid_out),
    .byte_ready_in(byte_ready_in), .busy_out(busy_out), .done_out(done_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference frame: a flat bit list built from the field rules, then bytes.
  bit         bq[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ref_q[$];
  int         exp_lat;
  int         last_first, last_done;

  task automatic push_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endtask

  function automatic logic [7:0] bits_to_byte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = bq[base+i];
    return b;
  endfunction

  task automatic build_model();
    logic [15:0] crc;
    bit fb;
    bq.delete();
    exp_q.delete();
    push_bits(64'hFFF, 12); push_bits(64'd1, 1); push_bits(64'd1, 2);
    push_bits({63'd0, ~crc_en_in}, 1);
    push_bits({60'd0, bitrate_idx_in}, 4); push_bits({62'd0, samp_idx_in}, 2);
    push_bits({63'd0, padding_in}, 1); push_bits({63'd0, private_in}, 1);
    push_bits({62'd0, mode_in}, 2); push_bits({62'd0, mode_ext_in}, 2);
    push_bits({63'd0, copyright_in}, 1); push_bits({63'd0, original_in}, 1);
    push_bits({62'd0, emphasis_in}, 2);
    push_bits({55'd0, main_data_begin_in}, 9);
    if (mode_in == 2'b11) begin
      push_bits({59'd0, private_bits_in}, 5);
      push_bits({60'd0, scfsi_in[7:4]}, 4);
      push_bits({5'd0, gc_info_in[0]}, 59);
      push_bits({5'd0, gc_info_in[2]}, 59);
    end else begin
      push_bits({61'd0, private_bits_in[2:0]}, 3);
      push_bits({56'd0, scfsi_in}, 8);
      for (int g = 0; g < 4; g++) push_bits({5'd0, gc_info_in[g]}, 59);
    end
    crc = 16'hFFFF;
    for (int i = 16; i < bq.size(); i++) begin
      fb  = crc[15] ^ bq[i];
      crc = {crc[14:0], 1'b0};
      if (fb) crc = crc ^ 16'h8005;
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(bits_to_byte(8 * k));
    if (crc_en_in) begin
      exp_q.push_back(crc[15:8]);
      exp_q.push_back(crc[7:0]);
    end
    for (int k = 4; k < bq.size() / 8; k++) exp_q.push_back(bits_to_byte(8 * k));
    exp_lat = crc_en_in ? 1 + (bq.size() - 16) : 1;
  endtask

  task automatic randomize_fields();
    logic [63:0] r;
    crc_en_in          = 1'($urandom);
    bitrate_idx_in     = 4'($urandom);
    samp_idx_in        = 2'($urandom);
    padding_in         = 1'($urandom);
    private_in         = 1'($urandom);
    copyright_in       = 1'($urandom);
    original_in        = 1'($urandom);
    mode_in            = 2'($urandom);
    mode_ext_in        = 2'($urandom);
    emphasis_in        = 2'($urandom);
    main_data_begin_in = 9'($urandom);
    private_bits_in    = 5'($urandom);
    scfsi_in           = 8'($urandom);
    for (int g = 0; g < 4; g++) begin
      r = {$urandom, $urandom};
      gc_info_in[g] = r[58:0];
    end
  endtask

  task automatic zero_fields();
    {crc_en_in, bitrate_idx_in, samp_idx_in, padding_in, private_in,
     copyright_in, original_in, mode_in, mode_ext_in, emphasis_in} = '0;
    main_data_begin_in = '0;
    private_bits_in    = '0;
    scfsi_in           = '0;
    gc_info_in         = '0;
  endtask

  logic [3:0][58:0] sv_gc;
  logic [63:0]      sv_misc;

  task automatic save_fields();
    sv_gc   = gc_info_in;
    sv_misc = {crc_en_in, bitrate_idx_in, samp_idx_in, padding_in, private_in,
               copyright_in, original_in, mode_in, mode_ext_in, emphasis_in,
               main_data_begin_in, private_bits_in, scfsi_in, 19'd0};
  endtask

  task automatic restore_fields();
    gc_info_in = sv_gc;
    {crc_en_in, bitrate_idx_in, samp_idx_in, padding_in, private_in,
     copyright_in, original_in, mode_in, mode_ext_in, emphasis_in,
     main_data_begin_in, private_bits_in, scfsi_in} = sv_misc[63:19];
  endtask

  // Called on a negedge with fields set. ready_mode 0 = always ready,
  // 1 = random ready. inject_at / abort_at are transfer counts, -1 = off.
  task automatic run_frame(input int ready_mode, input int inject_at, input int abort_at);
    int cyc, xfers, first, last_x, done_c;
    bit prev_stall, aborted;
    logic [7:0] prev_b;
    build_model();
    got_q.delete();
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    randomize_fields();
    cyc = 1; xfers = 0; first = -1; last_x = -1; done_c = -1;
    prev_stall = 0; aborted = 0; prev_b = '0;
    while (cyc < 2000) begin
      if (done_out) begin
        done_c = cyc;
        check("busy_at_done", busy_out, 0);
        break;
      end
      if (prev_stall) begin
        check("stall_valid", byte_valid_out, 1);
        check("stall_hold", byte_out, prev_b);
      end
      if (byte_valid_out && first < 0) first = cyc;
      byte_ready_in = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start_in = (inject_at >= 0 && xfers == inject_at);
      if (start_in) randomize_fields();
      if (byte_valid_out && byte_ready_in) begin
        got_q.push_back(byte_out);
        if (xfers < exp_q.size()) check("byte", byte_out, exp_q[xfers]);
        else check("byte_overrun", xfers, exp_q.size() - 1);
        xfers++;
        last_x = cyc;
      end
      prev_stall = byte_valid_out && !byte_ready_in;
      prev_b     = byte_out;
      if (abort_at >= 0 && xfers == abort_at) begin
        start_in = 1'b0;
        rst_in   = 1'b1;
        @(negedge clk_in);
        check("abort_valid", byte_valid_out, 0);
        check("abort_byte", byte_out, 0);
        check("abort_busy", busy_out, 0);
        check("abort_done", done_out, 0);
        rst_in  = 1'b0;
        aborted = 1;
        break;
      end
      @(negedge clk_in);
      cyc++;
    end
    start_in      = 1'b0;
    byte_ready_in = 1'b1;
    last_first    = first;
    last_done     = done_c;
    if (!aborted) begin
      check("done_cycle", done_c, last_x + 1);
      check("n_bytes", xfers, exp_q.size());
      check("latency", first, exp_lat);
      if (ready_mode == 0) check("frame_cycles", done_c, exp_lat + exp_q.size());
    end
  endtask

  initial begin
    rst_in = 1'b1; start_in = 1'b0; byte_ready_in = 1'b1;
    zero_fields();
    repeat (3) @(negedge clk_in);
    check("rst_valid", byte_valid_out, 0);
    check("rst_byte", byte_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Stereo unprotected, bitrate 9.
    zero_fields();
    bitrate_idx_in = 4'd9;
    run_frame(0, -1, -1);
    check("st_b0", got_q[0], 8'hFF);
    check("st_b1", got_q[1], 8'hFB);
    check("st_b2", got_q[2], 8'h90);
    check("st_b3", got_q[3], 8'h00);
    check("st_total", got_q.size(), 36);
    check("st_done37", last_done, 37);
    @(negedge clk_in);

    // Mono, main_data_begin all ones, gc all ones.
    zero_fields();
    mode_in = 2'b11;
    main_data_begin_in = 9'h1FF;
    gc_info_in = '1;
    run_frame(0, -1, -1);
    check("mo_b3", got_q[3], 8'hC0);
    check("mo_si0", got_q[4], 8'hFF);
    check("mo_si1", got_q[5], 8'h80);
    check("mo_total", got_q.size(), 21);
    @(negedge clk_in);

    // Protected stereo and protected mono.
    randomize_fields();
    crc_en_in = 1'b1;
    mode_in = 2'($urandom_range(0, 2));
    run_frame(0, -1, -1);
    check("pst_b0", got_q[0], 8'hFF);
    check("pst_b1", got_q[1], 8'hFA);
    check("pst_lat", last_first, 273);
    check("pst_total", got_q.size(), 38);
    randomize_fields();
    crc_en_in = 1'b1;
    mode_in = 2'b11;
    run_frame(0, -1, -1);
    check("pmo_lat", last_first, 153);
    check("pmo_total", got_q.size(), 23);
    @(negedge clk_in);

    // Backpressure must not change the byte sequence.
    for (int n = 0; n < 4; n++) begin
      randomize_fields();
      save_fields();
      run_frame(0, -1, -1);
      ref_q = got_q;
      @(negedge clk_in);
      restore_fields();
      run_frame(1, -1, -1);
      check("bp_len", got_q.size(), ref_q.size());
      for (int k = 0; k < ref_q.size() && k < got_q.size(); k++)
        check("bp_same", got_q[k], ref_q[k]);
      @(negedge clk_in);
    end

    // Back-to-back frames, each started in the done cycle of the previous.
    for (int n = 0; n < 6; n++) begin
      randomize_fields();
      run_frame(n % 2, -1, -1);
    end
    @(negedge clk_in);

    // Start during side info is ignored over a whole frame.
    randomize_fields();
    mode_in = 2'b00;
    crc_en_in = 1'b1;
    run_frame(1, 20, -1);
    @(negedge clk_in);

    // Start during side info, then reset at byte 10, then a clean frame.
    randomize_fields();
    mode_in = 2'b01;
    crc_en_in = 1'b0;
    run_frame(0, 6, 10);
    @(negedge clk_in);
    check("post_abort_done", done_out, 0);
    randomize_fields();
    run_frame(1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
